// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file.
// Provides the default address and data widths, the write-counter width with
// its saturation value, and a saturating increment for that counter.
// Used by regfile_dec. No ports.
package regfile_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   // The counter sticks at CNT_MAX instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/decoder_n_onehot.sv
// decoder_n_onehot: N-bit binary to 2**N one-hot decoder with enable.
// Ports:
//   x  - binary index. The LSB of x is the least significant index bit.
//   en - enable. When it is 0, z is all zeros.
//   z  - one-hot output. Bit i is set iff en=1 and x==i.
module decoder_n_onehot #(
   parameter int N = 5
) (
   input  logic [N-1:0]      x,
   input  logic              en,
   output logic [2**N-1:0]   z
);

   always_comb begin
      z = '0;
      if (en) z[x] = 1'b1;
   end

endmodule

// File: rtl/regfile_dec.sv
// regfile_dec: register file with one write port and two read ports.
// The write select is decoded to one-hot. The module also keeps a registered
// copy of the last accepted select and a saturating count of accepted writes.
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   we, waddr, wdata   - write port
//   raddr_a, rdata_a   - read port A (combinational)
//   raddr_b, rdata_b   - read port B (combinational)
//   wsel_q             - one-hot select of the last accepted write
//   wr_cnt             - accepted writes since reset; saturates at 16'hFFFF
//
// Build option:
//   REGFILE_DEC_BYPASS_EN - when defined, a read at the address of the write
//   accepted in the same cycle returns wdata. When undefined, that read returns
//   the stored value, and the new value appears on the next cycle.
module regfile_dec
   import regfile_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int R0_ZERO = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [ADDR_W-1:0]     raddr_a,
   output logic [DATA_W-1:0]     rdata_a,
   input  logic [ADDR_W-1:0]     raddr_b,
   output logic [DATA_W-1:0]     rdata_b,
   output logic [2**ADDR_W-1:0]  wsel_q,
   output logic [CNT_W-1:0]      wr_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  wsel;
   logic              accept;

   decoder_n_onehot #(.N(ADDR_W)) u_dec (
      .x  (waddr),
      .en (we),
      .z  (wsel)
   );

   // A write to the hardwired-zero entry is dropped entirely.
   // It changes no storage, no select register and no counter.
   assign accept = we && !((R0_ZERO != 0) && (waddr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wsel_q <= '0;
         wr_cnt <= '0;
      end else if (accept) begin
         mem[waddr] <= wdata;
         wsel_q     <= wsel;
         wr_cnt     <= sat_inc(wr_cnt);
      end
   end

   always_comb begin
      rdata_a = mem[raddr_a];
      rdata_b = mem[raddr_b];
      if ((R0_ZERO != 0) && (raddr_a == '0)) rdata_a = '0;
      if ((R0_ZERO != 0) && (raddr_b == '0)) rdata_b = '0;
`ifdef REGFILE_DEC_BYPASS_EN
      // Forwarding applies only to a write that will actually land this edge.
      // That means no reset is active and the write is accepted.
      if (!rst && accept && (raddr_a == waddr)) rdata_a = wdata;
      if (!rst && accept && (raddr_b == waddr)) rdata_b = wdata;
`endif
   end

endmodule
